// File: rtl/n1_pkg.sv
// rtl/n1_pkg.sv - shared state encoding and round-robin constants for the stack-bus arbiter
package n1_pkg;

  typedef enum logic [1:0] {
    SARB_IDLE = 2'b00,
    SARB_PS   = 2'b01,
    SARB_RS   = 2'b10
  } sarb_state_e;

  // Round-robin flag records which requester was served last.
  localparam logic RR_PS_LAST = 1'b0;
  localparam logic RR_RS_LAST = 1'b1;

  localparam int unsigned SARB_DAT_W = 16;

endpackage

// File: rtl/n1_sarb.sv
// rtl/n1_sarb.sv - pipelined Wishbone arbiter merging the PS and RS stack ports onto one stack bus
module n1_sarb
  import n1_pkg::*;
#(
  parameter int SP_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,

  input  logic                  ps2sarb_cyc_i,
  input  logic                  ps2sarb_stb_i,
  input  logic                  ps2sarb_we_i,
  input  logic [SP_WIDTH-1:0]   ps2sarb_adr_i,
  input  logic [SARB_DAT_W-1:0] ps2sarb_dat_i,
  output logic                  sarb2ps_ack_o,
  output logic                  sarb2ps_err_o,
  output logic                  sarb2ps_rty_o,
  output logic                  sarb2ps_stall_o,
  output logic [SARB_DAT_W-1:0] sarb2ps_dat_o,

  input  logic                  rs2sarb_cyc_i,
  input  logic                  rs2sarb_stb_i,
  input  logic                  rs2sarb_we_i,
  input  logic [SP_WIDTH-1:0]   rs2sarb_adr_i,
  input  logic [SARB_DAT_W-1:0] rs2sarb_dat_i,
  output logic                  sarb2rs_ack_o,
  output logic                  sarb2rs_err_o,
  output logic                  sarb2rs_rty_o,
  output logic                  sarb2rs_stall_o,
  output logic [SARB_DAT_W-1:0] sarb2rs_dat_o,

  output logic                  sarb2sbus_cyc_o,
  output logic                  sarb2sbus_stb_o,
  output logic                  sarb2sbus_we_o,
  output logic [SP_WIDTH:0]     sarb2sbus_adr_o,
  output logic [SARB_DAT_W-1:0] sarb2sbus_dat_o,
  input  logic                  sbus2sarb_ack_i,
  input  logic                  sbus2sarb_err_i,
  input  logic                  sbus2sarb_rty_i,
  input  logic                  sbus2sarb_stall_i,
  input  logic [SARB_DAT_W-1:0] sbus2sarb_dat_i,

  output logic [1:0]            prb_sarb_state_o
);

  sarb_state_e state_q, state_d;
  logic        rr_q, rr_d;
  logic        grant_ps, grant_rs;

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q <= SARB_IDLE;
      rr_q    <= RR_RS_LAST;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Grants are combinational so the IDLE winner reaches the bus in the same
  // cycle; the async reset masks them so the bus drops immediately.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_ps = 1'b0;
    grant_rs = 1'b0;
    unique case (state_q)
      SARB_IDLE: begin
        if (ps2sarb_cyc_i && rs2sarb_cyc_i) begin
          grant_ps = (rr_q == RR_RS_LAST);
          grant_rs = (rr_q == RR_PS_LAST);
        end else begin
          grant_ps = ps2sarb_cyc_i;
          grant_rs = rs2sarb_cyc_i;
        end
        if (grant_ps) begin
          state_d = SARB_PS;
          rr_d    = RR_PS_LAST;
        end else if (grant_rs) begin
          state_d = SARB_RS;
          rr_d    = RR_RS_LAST;
        end
      end
      SARB_PS: begin
        grant_ps = ps2sarb_cyc_i;
        if (!ps2sarb_cyc_i) state_d = SARB_IDLE;
      end
      SARB_RS: begin
        grant_rs = rs2sarb_cyc_i;
        if (!rs2sarb_cyc_i) state_d = SARB_IDLE;
      end
      default: state_d = SARB_IDLE;
    endcase
    if (async_rst_i) begin
      grant_ps = 1'b0;
      grant_rs = 1'b0;
    end
    if (sync_rst_i) begin
      state_d = SARB_IDLE;
      rr_d    = RR_RS_LAST;
    end
  end

  always_comb begin
    sarb2sbus_cyc_o = 1'b0;
    sarb2sbus_stb_o = 1'b0;
    sarb2sbus_we_o  = 1'b0;
    sarb2sbus_adr_o = '0;
    sarb2sbus_dat_o = '0;
    if (grant_ps) begin
      sarb2sbus_cyc_o = ps2sarb_cyc_i;
      sarb2sbus_stb_o = ps2sarb_stb_i;
      sarb2sbus_we_o  = ps2sarb_we_i;
      sarb2sbus_adr_o = {1'b0, ps2sarb_adr_i};
      sarb2sbus_dat_o = ps2sarb_dat_i;
    end else if (grant_rs) begin
      sarb2sbus_cyc_o = rs2sarb_cyc_i;
      sarb2sbus_stb_o = rs2sarb_stb_i;
      sarb2sbus_we_o  = rs2sarb_we_i;
      sarb2sbus_adr_o = {1'b1, rs2sarb_adr_i};
      sarb2sbus_dat_o = rs2sarb_dat_i;
    end
  end

  // A requester that is not granted sees stall so it holds its request.
  always_comb begin
    sarb2ps_ack_o   = grant_ps & sbus2sarb_ack_i;
    sarb2ps_err_o   = grant_ps & sbus2sarb_err_i;
    sarb2ps_rty_o   = grant_ps & sbus2sarb_rty_i;
    sarb2ps_stall_o = grant_ps ? sbus2sarb_stall_i : ps2sarb_cyc_i;
    sarb2ps_dat_o   = grant_ps ? sbus2sarb_dat_i : '0;
    sarb2rs_ack_o   = grant_rs & sbus2sarb_ack_i;
    sarb2rs_err_o   = grant_rs & sbus2sarb_err_i;
    sarb2rs_rty_o   = grant_rs & sbus2sarb_rty_i;
    sarb2rs_stall_o = grant_rs ? sbus2sarb_stall_i : rs2sarb_cyc_i;
    sarb2rs_dat_o   = grant_rs ? sbus2sarb_dat_i : '0;
  end

  assign prb_sarb_state_o = state_q;

`ifdef FORMAL
  wb_syscon u_wb_syscon (
    .clk_i (clk_i),
    .rst_i (async_rst_i | sync_rst_i)
  );
`endif

endmodule
